// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and other bus masters on the
// CPU's 8-bit bus: default geometry, FSM state encoding, and the bit
// positions of the bus-control word shared with the instruction decoder.
package program_loader_pkg;

    localparam int unsigned PL_ADDR_W = 4;
    localparam int unsigned PL_DATA_W = 8;
    localparam int unsigned PL_DEPTH  = 16;

    localparam int unsigned PL_STATE_W = 3;

    typedef enum logic [PL_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } pl_state_e;

    // Bus-control bit positions; MI/RI match the decoder's control word names.
    localparam int unsigned CTRL_MI     = 0;  // mar_load
    localparam int unsigned CTRL_RI     = 1;  // ram_write
    localparam int unsigned CTRL_BUS_OE = 2;  // this master drives the bus
    localparam int unsigned CTRL_READY  = 3;  // host stream ready
    localparam int unsigned CTRL_HOLD   = 4;  // CPU held in reset
    localparam int unsigned CTRL_BUSY   = 5;  // load in progress
    localparam int unsigned CTRL_DONE   = 6;  // final word written
    localparam int unsigned CTRL_W      = 7;

    typedef logic [CTRL_W-1:0] pl_ctrl_t;

    // Moore output decode: the control word that belongs to each state.
    function automatic pl_ctrl_t pl_ctrl_for(input pl_state_e s);
        pl_ctrl_t c;
        c = '0;
        case (s)
            ST_ADDR: begin
                c[CTRL_MI]     = 1'b1;
                c[CTRL_BUS_OE] = 1'b1;
                c[CTRL_HOLD]   = 1'b1;
                c[CTRL_BUSY]   = 1'b1;
            end
            ST_WAIT: begin
                c[CTRL_READY]  = 1'b1;
                c[CTRL_HOLD]   = 1'b1;
                c[CTRL_BUSY]   = 1'b1;
            end
            ST_WRITE: begin
                c[CTRL_RI]     = 1'b1;
                c[CTRL_BUS_OE] = 1'b1;
                c[CTRL_HOLD]   = 1'b1;
                c[CTRL_BUSY]   = 1'b1;
            end
            ST_DONE: begin
                c[CTRL_DONE]   = 1'b1;
                c[CTRL_HOLD]   = 1'b1;
                c[CTRL_BUSY]   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: writes a program image into the CPU's RAM over the shared
// bus before execution. Each host byte costs ADDR (address -> MAR), WAIT
// (stream handshake) and WRITE (data -> RAM[MAR]); the CPU is held in reset
// for the whole load and released after a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse, begins a load when idle
//   in_data/in_valid  host byte stream; in_ready high while waiting for a byte
//   bus               shared CPU bus, driven only in ADDR and WRITE
//   mar_load          MAR loads from bus on the next rising edge
//   ram_write         RAM[MAR] loads from bus on the next rising edge
//   cpu_hold          OR'd into the CPU reset while loading
//   busy              load in progress
//   done              one-cycle pulse after the final word is written
//   checksum          mod-2^DATA_W sum of bytes accepted in the current/last load
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = PL_ADDR_W,
    parameter int unsigned DATA_W = PL_DATA_W,
    parameter int unsigned DEPTH  = PL_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    inout  wire  [DATA_W-1:0] bus,
    output logic              mar_load,
    output logic              ram_write,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    pl_state_e         r_state;
    pl_ctrl_t          r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] r_checksum;

    logic [DATA_W-1:0] w_bus_val;
    logic              w_last_word;

    assign w_last_word = (r_addr == ADDR_W'(DEPTH - 1));

    // Loader FSM; r_ctrl is loaded with the decode of the state being entered
    // so every control output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_addr     <= '0;
            r_data_q   <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_ADDR;
                        r_ctrl     <= pl_ctrl_for(ST_ADDR);
                        r_addr     <= '0;
                        r_checksum <= '0;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_WAIT;
                    r_ctrl  <= pl_ctrl_for(ST_WAIT);
                end
                ST_WAIT: begin
                    // in_ready is high in this state, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        r_data_q   <= in_data;
                        r_checksum <= r_checksum + in_data;
                        r_state    <= ST_WRITE;
                        r_ctrl     <= pl_ctrl_for(ST_WRITE);
                    end
                end
                ST_WRITE: begin
                    if (w_last_word) begin
                        r_state <= ST_DONE;
                        r_ctrl  <= pl_ctrl_for(ST_DONE);
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= ST_ADDR;
                        r_ctrl  <= pl_ctrl_for(ST_ADDR);
                    end
                end
                ST_DONE: begin
                    // A start seen here is dropped; the next load needs a start in IDLE.
                    r_state <= ST_IDLE;
                    r_ctrl  <= pl_ctrl_for(ST_IDLE);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    // Address phase carries the zero-extended word address, write phase the byte.
    assign w_bus_val = r_ctrl[CTRL_RI] ? r_data_q : DATA_W'(r_addr);

    assign bus = r_ctrl[CTRL_BUS_OE] ? w_bus_val : {DATA_W{1'bz}};

    assign mar_load  = r_ctrl[CTRL_MI];
    assign ram_write = r_ctrl[CTRL_RI];
    assign in_ready  = r_ctrl[CTRL_READY];
    assign cpu_hold  = r_ctrl[CTRL_HOLD];
    assign busy      = r_ctrl[CTRL_BUSY];
    assign done      = r_ctrl[CTRL_DONE];
    assign checksum  = r_checksum;

endmodule
